// File: rtl/bus_arbiter.sv
// Two-master round-robin arbiter onto a single shared slave bus.
// Each master gets one pending slot; the bus runs IDLE -> ISSUE -> WAIT with a timeout.
module bus_arbiter #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  input  logic [3:0]  m0_wmask,
  input  logic        m0_rstrb,
  output logic [31:0] m0_rdata,
  output logic        m0_rbusy,
  output logic        m0_wbusy,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  input  logic [3:0]  m1_wmask,
  input  logic        m1_rstrb,
  output logic [31:0] m1_rdata,
  output logic        m1_rbusy,
  output logic        m1_wbusy,
  output logic [31:0] s_addr,
  output logic [31:0] s_wdata,
  output logic [3:0]  s_wmask,
  output logic        s_rstrb,
  input  logic [31:0] s_rdata,
  input  logic        s_ack,
  output logic        gnt_id,
  output logic        busy,
  input  logic        err_clr,
  output logic        timeout_err,
  output logic [1:0]  dbg_state_o
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2
  } state_e;

  localparam logic [7:0]  CNT_LAST      = 8'(TIMEOUT - 1);
  localparam logic [31:0] TIMEOUT_RDATA = 32'hDEADBEEF;

  state_e            state_q, state_d;
  logic [1:0]        pend_q, pend_d;
  logic [1:0]        wr_q, wr_d;
  logic [1:0][31:0]  addr_q, addr_d;
  logic [1:0][31:0]  wdata_q, wdata_d;
  logic [1:0][3:0]   wmask_q, wmask_d;
  logic [1:0][31:0]  rdata_q, rdata_d;
  logic [31:0]       s_addr_q, s_addr_d;
  logic [31:0]       s_wdata_q, s_wdata_d;
  logic [3:0]        s_wmask_q, s_wmask_d;
  logic              s_rstrb_q, s_rstrb_d;
  logic              gnt_q, gnt_d;
  logic              last_q, last_d;
  logic              err_q, err_d;
  logic [7:0]        cnt_q, cnt_d;

  logic [1:0][31:0]  m_addr, m_wdata;
  logic [1:0][3:0]   m_wmask;
  logic [1:0]        m_rstrb;
  logic              grant_sel;

  assign m_addr  = {m1_addr, m0_addr};
  assign m_wdata = {m1_wdata, m0_wdata};
  assign m_wmask = {m1_wmask, m0_wmask};
  assign m_rstrb = {m1_rstrb, m0_rstrb};

  // last_q holds the master served most recently; reset value 1 favours m0.
  assign grant_sel = (&pend_q) ? ~last_q : pend_q[1];

  always_comb begin
    state_d   = state_q;
    pend_d    = pend_q;
    wr_d      = wr_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    wmask_d   = wmask_q;
    rdata_d   = rdata_q;
    s_addr_d  = s_addr_q;
    s_wdata_d = s_wdata_q;
    s_wmask_d = 4'h0;
    s_rstrb_d = 1'b0;
    gnt_d     = gnt_q;
    last_d    = last_q;
    cnt_d     = cnt_q;
    err_d     = err_q;

    if (err_clr) err_d = 1'b0;

    for (int i = 0; i < 2; i++) begin
      if (((|m_wmask[i]) || m_rstrb[i]) && !pend_q[i]) begin
        pend_d[i]  = 1'b1;
        wr_d[i]    = |m_wmask[i];
        addr_d[i]  = m_addr[i];
        wdata_d[i] = m_wdata[i];
        wmask_d[i] = m_wmask[i];
      end
    end

    case (state_q)
      S_IDLE: begin
        if (|pend_q) begin
          state_d   = S_ISSUE;
          gnt_d     = grant_sel;
          s_addr_d  = addr_q[grant_sel];
          s_wdata_d = wdata_q[grant_sel];
          if (wr_q[grant_sel]) s_wmask_d = wmask_q[grant_sel];
          else                 s_rstrb_d = 1'b1;
        end
      end
      S_ISSUE: begin
        state_d = S_WAIT;
        cnt_d   = 8'd0;
      end
      S_WAIT: begin
        // An ack in the limit cycle still counts as a normal completion.
        if (s_ack || cnt_q == CNT_LAST) begin
          state_d       = S_IDLE;
          pend_d[gnt_q] = 1'b0;
          last_d        = gnt_q;
          if (!wr_q[gnt_q]) rdata_d[gnt_q] = s_ack ? s_rdata : TIMEOUT_RDATA;
          if (!s_ack) err_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      pend_q    <= '0;
      wr_q      <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      wmask_q   <= '0;
      rdata_q   <= '0;
      s_addr_q  <= '0;
      s_wdata_q <= '0;
      s_wmask_q <= '0;
      s_rstrb_q <= 1'b0;
      gnt_q     <= 1'b0;
      last_q    <= 1'b1;
      cnt_q     <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      pend_q    <= pend_d;
      wr_q      <= wr_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      wmask_q   <= wmask_d;
      rdata_q   <= rdata_d;
      s_addr_q  <= s_addr_d;
      s_wdata_q <= s_wdata_d;
      s_wmask_q <= s_wmask_d;
      s_rstrb_q <= s_rstrb_d;
      gnt_q     <= gnt_d;
      last_q    <= last_d;
      cnt_q     <= cnt_d;
      err_q     <= err_d;
    end
  end

  assign m0_rbusy    = pend_q[0] & ~wr_q[0];
  assign m0_wbusy    = pend_q[0] &  wr_q[0];
  assign m1_rbusy    = pend_q[1] & ~wr_q[1];
  assign m1_wbusy    = pend_q[1] &  wr_q[1];
  assign m0_rdata    = rdata_q[0];
  assign m1_rdata    = rdata_q[1];
  assign s_addr      = s_addr_q;
  assign s_wdata     = s_wdata_q;
  assign s_wmask     = s_wmask_q;
  assign s_rstrb     = s_rstrb_q;
  assign gnt_id      = gnt_q;
  assign busy        = (state_q != S_IDLE);
  assign timeout_err = err_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// Bench for bus_arbiter: directed scenarios plus random traffic, checked by a
// transaction-level reference model feeding expected queues to a monitor.
module tb_bus_arbiter;
  localparam int TMO = 15;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n = 1'b0;
  logic [31:0] m0_addr = '0, m0_wdata = '0, m1_addr = '0, m1_wdata = '0;
  logic [3:0]  m0_wmask = '0, m1_wmask = '0;
  logic        m0_rstrb = 1'b0, m1_rstrb = 1'b0;
  logic [31:0] m0_rdata, m1_rdata;
  logic        m0_rbusy, m0_wbusy, m1_rbusy, m1_wbusy;
  logic [31:0] s_addr, s_wdata;
  logic [3:0]  s_wmask;
  logic        s_rstrb;
  logic [31:0] s_rdata = '0;
  logic        s_ack = 1'b0;
  logic        gnt_id, busy;
  logic        err_clr = 1'b0;
  logic        timeout_err;
  logic [1:0]  dbg_state;

  bus_arbiter #(.TIMEOUT(TMO)) dut (
    .clk(clk), .reset_n(reset_n),
    .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_wmask(m0_wmask), .m0_rstrb(m0_rstrb),
    .m0_rdata(m0_rdata), .m0_rbusy(m0_rbusy), .m0_wbusy(m0_wbusy),
    .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_wmask(m1_wmask), .m1_rstrb(m1_rstrb),
    .m1_rdata(m1_rdata), .m1_rbusy(m1_rbusy), .m1_wbusy(m1_wbusy),
    .s_addr(s_addr), .s_wdata(s_wdata), .s_wmask(s_wmask), .s_rstrb(s_rstrb),
    .s_rdata(s_rdata), .s_ack(s_ack), .gnt_id(gnt_id), .busy(busy),
    .err_clr(err_clr), .timeout_err(timeout_err), .dbg_state_o(dbg_state)
  );

  typedef struct packed {
    int unsigned cyc;
    logic        id;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wmask;
    logic        rstrb;
  } issue_t;

  // Per-cycle status: {m0_rbusy,m0_wbusy,m1_rbusy,m1_wbusy,busy,timeout_err,m0_rdata,m1_rdata}
  logic [69:0] exp_q[$];
  issue_t      issue_q[$];
  logic [0:0]  compl_q[$];
  int          n_tests = 0;
  int          n_fail  = 0;
  int unsigned cyc     = 0;

  // Reference model: a pending slot per master and one bus transaction in flight.
  logic [1:0]  mdl_pend;
  logic        mdl_wr[2];
  logic [31:0] mdl_addr[2], mdl_wdata[2], mdl_rdata[2];
  logic [3:0]  mdl_wmask[2];
  logic        mdl_last, mdl_active, mdl_gnt, mdl_err;
  int unsigned mdl_grant_c;
  int          sched_ack;

  // Stimulus knobs; strobes, err_clr and forced ack are one-shot.
  logic        st_rst_n = 1'b0;
  logic        st_rd[2];
  logic [3:0]  st_wm[2];
  logic [31:0] st_addr[2], st_wdata[2];
  logic        st_clr = 1'b0, st_ack_force = 1'b0, st_fix_en = 1'b0;
  logic [31:0] st_fix_val = '0;
  int          st_delay = -1;
  int          spur_pct = 10;

  task automatic model_reset();
    mdl_pend   = 2'b00;
    mdl_last   = 1'b1;
    mdl_active = 1'b0;
    mdl_gnt    = 1'b0;
    mdl_err    = 1'b0;
    sched_ack  = -1;
    for (int m = 0; m < 2; m++) begin
      mdl_wr[m] = 1'b0; mdl_rdata[m] = '0; mdl_addr[m] = '0; mdl_wdata[m] = '0; mdl_wmask[m] = '0;
    end
    issue_q.delete();
    compl_q.delete();
  endtask

  function automatic int pick_delay();
    int r;
    r = $urandom_range(9);
    if (r <= 5) return $urandom_range(3);
    if (r == 6) return TMO - 1;
    if (r == 7) return TMO;
    if (r == 8) return TMO + 3;
    return $urandom_range(10, 4);
  endfunction

  task automatic tick();
    logic       ack, in_wait, done, was_active, g;
    logic [1:0] pend_n;
    issue_t     ie;
    int         d;
    @(negedge clk);
    reset_n  = st_rst_n;
    m0_rstrb = st_rd[0]; m0_wmask = st_wm[0]; m0_addr = st_addr[0]; m0_wdata = st_wdata[0];
    m1_rstrb = st_rd[1]; m1_wmask = st_wm[1]; m1_addr = st_addr[1]; m1_wdata = st_wdata[1];
    err_clr  = st_clr;
    s_rdata  = st_fix_en ? st_fix_val : $urandom;
    in_wait  = mdl_active && (cyc >= mdl_grant_c + 2);
    if (in_wait) ack = (int'(cyc) == sched_ack);
    else         ack = st_ack_force || ($urandom_range(99) < spur_pct);
    s_ack = ack;
    if (!st_rst_n) begin
      model_reset();
      exp_q.push_back('0);
    end else begin
      was_active = mdl_active;
      done   = in_wait && (ack || cyc == mdl_grant_c + 1 + TMO);
      pend_n = mdl_pend;
      if (done) begin
        pend_n[mdl_gnt] = 1'b0;
        mdl_last        = mdl_gnt;
        if (!mdl_wr[mdl_gnt]) mdl_rdata[mdl_gnt] = ack ? s_rdata : 32'hDEADBEEF;
        compl_q.push_back(mdl_gnt);
        mdl_active = 1'b0;
      end
      if (st_clr) mdl_err = 1'b0;
      if (done && !ack) mdl_err = 1'b1;
      for (int m = 0; m < 2; m++) begin
        if ((st_rd[m] || st_wm[m] != 4'h0) && !mdl_pend[m]) begin
          pend_n[m]    = 1'b1;
          mdl_wr[m]    = (st_wm[m] != 4'h0);
          mdl_addr[m]  = st_addr[m];
          mdl_wdata[m] = st_wdata[m];
          mdl_wmask[m] = st_wm[m];
        end
      end
      if (!was_active && mdl_pend != 2'b00) begin
        // Both waiting: the one not served last; otherwise whoever is waiting.
        if (mdl_pend == 2'b11) g = !mdl_last;
        else                   g = (mdl_pend == 2'b10);
        ie.cyc   = cyc + 1;
        ie.id    = g;
        ie.addr  = mdl_addr[g];
        ie.wdata = mdl_wdata[g];
        ie.wmask = mdl_wr[g] ? mdl_wmask[g] : 4'h0;
        ie.rstrb = !mdl_wr[g];
        issue_q.push_back(ie);
        mdl_active  = 1'b1;
        mdl_gnt     = g;
        mdl_grant_c = cyc;
        d = (st_delay >= 0) ? st_delay : pick_delay();
        st_delay  = -1;
        sched_ack = (d < TMO) ? int'(cyc) + 2 + d : -1;
      end
      mdl_pend = pend_n;
      exp_q.push_back({mdl_pend[0] & !mdl_wr[0], mdl_pend[0] & mdl_wr[0],
                       mdl_pend[1] & !mdl_wr[1], mdl_pend[1] & mdl_wr[1],
                       mdl_active, mdl_err, mdl_rdata[0], mdl_rdata[1]});
    end
    st_rd[0] = 1'b0; st_rd[1] = 1'b0; st_wm[0] = 4'h0; st_wm[1] = 4'h0;
    st_clr = 1'b0; st_ack_force = 1'b0;
  endtask

  task automatic settle();
    for (int i = 0; i < 200; i++) begin
      if (!mdl_active && mdl_pend == 2'b00) break;
      tick();
    end
    n_tests++;
    if (mdl_active || mdl_pend != 2'b00) begin
      n_fail++;
      $display("FAIL settle_budget actual=still busy required=idle within 200 cycles");
    end
  endtask

  // Monitor: samples just after each rising edge and pops the expected queues.
  initial begin
    logic [69:0] e, act;
    issue_t      ie;
    logic [0:0]  c;
    logic        prev_busy;
    prev_busy = 1'b0;
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      if (exp_q.size() > 0) begin
        e   = exp_q.pop_front();
        act = {m0_rbusy, m0_wbusy, m1_rbusy, m1_wbusy, busy, timeout_err, m0_rdata, m1_rdata};
        n_tests++;
        if (act !== e) begin
          n_fail++;
          $display("FAIL status cyc=%0d actual=%h required=%h", cyc, act, e);
        end
      end
      if (s_rstrb || s_wmask != 4'h0) begin
        n_tests++;
        if (issue_q.size() == 0 || issue_q[0].cyc != cyc) begin
          n_fail++;
          $display("FAIL issue_unexpected cyc=%0d actual id=%0d addr=%h rstrb=%b wmask=%b required no issue",
                   cyc, gnt_id, s_addr, s_rstrb, s_wmask);
        end else begin
          ie = issue_q.pop_front();
          if ({gnt_id, s_addr, s_wdata, s_wmask, s_rstrb} !== {ie.id, ie.addr, ie.wdata, ie.wmask, ie.rstrb}) begin
            n_fail++;
            $display("FAIL issue_payload cyc=%0d actual=%0d/%h/%h/%b/%b required=%0d/%h/%h/%b/%b", cyc,
                     gnt_id, s_addr, s_wdata, s_wmask, s_rstrb, ie.id, ie.addr, ie.wdata, ie.wmask, ie.rstrb);
          end
        end
      end else if (issue_q.size() > 0 && issue_q[0].cyc == cyc) begin
        n_tests++;
        n_fail++;
        $display("FAIL issue_missing cyc=%0d actual=no issue required id=%0d addr=%h", cyc, issue_q[0].id, issue_q[0].addr);
        void'(issue_q.pop_front());
      end
      if (reset_n && prev_busy && !busy) begin
        n_tests++;
        if (compl_q.size() == 0) begin
          n_fail++;
          $display("FAIL completion_unexpected cyc=%0d actual gnt=%0d required none", cyc, gnt_id);
        end else begin
          c = compl_q.pop_front();
          if (gnt_id !== c[0]) begin
            n_fail++;
            $display("FAIL completion_gnt cyc=%0d actual=%0d required=%0d", cyc, gnt_id, c[0]);
          end
        end
      end
      prev_busy = reset_n && busy;
    end
  end

  initial begin
    int t;
    for (int m = 0; m < 2; m++) begin
      st_rd[m] = 1'b0; st_wm[m] = 4'h0; st_addr[m] = '0; st_wdata[m] = '0;
    end
    model_reset();

    st_rst_n = 1'b0;
    repeat (3) tick();
    st_rst_n = 1'b1;

    // Single read with an immediate ack.
    st_rd[0] = 1'b1; st_addr[0] = 32'h100; st_wdata[0] = $urandom;
    st_delay = 0; st_fix_en = 1'b1; st_fix_val = 32'h12345678;
    repeat (7) tick();
    st_fix_en = 1'b0;

    // Simultaneous pairs, then m0 alone followed by another pair.
    st_rd[0] = 1'b1; st_rd[1] = 1'b1; st_addr[0] = $urandom; st_addr[1] = $urandom;
    tick(); settle();
    st_rd[0] = 1'b1; st_rd[1] = 1'b1; st_addr[0] = $urandom; st_addr[1] = $urandom;
    tick(); settle();
    st_rd[0] = 1'b1; tick(); settle();
    st_rd[0] = 1'b1; st_rd[1] = 1'b1; tick(); settle();

    // m1 partial write.
    st_wm[1] = 4'b0011; st_wdata[1] = 32'hAABBCCDD; st_addr[1] = 32'h40000000;
    tick(); settle();

    // Read that times out, then clear the error flag.
    st_rd[0] = 1'b1; st_delay = 99; tick(); settle();
    repeat (3) tick();
    st_clr = 1'b1; tick();
    repeat (2) tick();

    // Repeated strobes while m0 is already pending.
    st_rd[0] = 1'b1; st_delay = 2; tick();
    st_rd[0] = 1'b1; tick();
    st_rd[0] = 1'b1; tick();
    settle();

    // Ack in the last permitted cycle, then timeout coinciding with err_clr.
    st_rd[1] = 1'b1; st_delay = TMO - 1; tick(); settle();
    st_rd[0] = 1'b1; st_delay = 99; tick();
    repeat (TMO + 1) tick();
    st_clr = 1'b1; tick();
    settle();

    // Reset in the middle of WAIT, then a stale ack after release.
    st_rd[0] = 1'b1; st_delay = 99; tick();
    repeat (4) tick();
    st_rst_n = 1'b0; tick(); tick();
    st_rst_n = 1'b1; st_ack_force = 1'b1; tick();
    repeat (3) tick();

    // Random traffic.
    for (int n = 0; n < 1200; n++) begin
      for (int m = 0; m < 2; m++) begin
        st_addr[m]  = $urandom;
        st_wdata[m] = $urandom;
        if ($urandom_range(99) < 30) begin
          t = $urandom_range(2);
          st_rd[m] = (t != 1);
          st_wm[m] = (t == 0) ? 4'h0 : 4'($urandom_range(15, 1));
        end
      end
      st_clr = ($urandom_range(99) < 3);
      tick();
    end
    settle();
    repeat (3) tick();

    n_tests++;
    if (issue_q.size() != 0 || compl_q.size() != 0) begin
      n_fail++;
      $display("FAIL leftover_expectations actual issue=%0d compl=%0d required 0/0", issue_q.size(), compl_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
